markov_predictor_n: RTL and testbench

//  Parametrised order-N Markov predictor for the rock-paper-scissors (RPS) engine.

---
 rtl/markov_predictor_n.sv | 170 +++++++++++++++++
 tb/tb_markov_predictor_n.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/markov_predictor_n.sv
// Order-N Markov move predictor for the rock-paper-scissors engine.
// Learns user transitions per context row and plays the move that beats the likeliest one.
module markov_predictor_n #(
  parameter int HIST    = 1,
  parameter int CNT_W   = 8,
  parameter int SCORE_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               move_valid,
  input  logic [1:0]         move_user,
  output logic               ready,
  output logic [1:0]         choice,
  output logic               choice_valid,
  output logic               err,
  output logic [SCORE_W-1:0] comp_wins,
  output logic [SCORE_W-1:0] user_wins,
  output logic [SCORE_W-1:0] draws
);

  localparam int ROWS = 4 ** HIST;
  localparam int CW   = 2 * HIST;
  localparam int HW   = $clog2(HIST + 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_UPDATE,
    S_PREDICT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_crow;
  logic [CW-1:0]      r_ctx;
  logic [HW-1:0]      r_hcnt;
  logic [1:0]         r_rnd;
  logic [1:0]         r_mv;
  logic [1:0]         r_choice;
  logic               r_cv;
  logic               r_err;
  logic [SCORE_W-1:0] r_cwin;
  logic [SCORE_W-1:0] r_uwin;
  logic [SCORE_W-1:0] r_draw;

  logic [CNT_W-1:0]   r_tab [ROWS][3];
  logic [CNT_W-1:0]   w_row [3];
  logic [CNT_W-1:0]   w_new [3];
  logic [CNT_W-1:0]   w_max;
  logic [2:0]         w_m;
  logic [1:0]         w_pred;
  logic               w_sat;
  logic               w_kill;
  logic               w_acc;
  logic               w_bad;
  logic               w_full;
  logic [CW-1:0]      w_ctx_n;

  function automatic logic [1:0] f_beat(input logic [1:0] m);
    case (m)
      2'b00:   f_beat = 2'b10;
      2'b01:   f_beat = 2'b00;
      default: f_beat = 2'b01;
    endcase
  endfunction

  assign w_kill  = reset | clear;
  assign w_acc   = (r_state == S_IDLE) & move_valid
                 & (move_user != 2'b11);
  assign w_bad   = (r_state == S_IDLE) & move_valid
                 & (move_user == 2'b11);
  assign w_full  = (r_hcnt == HW'(HIST));
  assign w_ctx_n = CW'({r_ctx, r_mv});

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR:   if (r_crow == CW'(ROWS - 1)) w_next = S_IDLE;
      S_IDLE:    if (w_acc) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_PREDICT;
      S_PREDICT: w_next = S_IDLE;
    endcase
  end

  // One read port serves both the RMW in UPDATE and the lookup in PREDICT
  always_comb begin
    w_sat = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_row[k] = r_tab[r_ctx][k];
      if (r_mv == 2'(k) && w_row[k] == '1) w_sat = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      w_new[k] = w_sat ? (w_row[k] >> 1) : w_row[k];
      if (r_mv == 2'(k)) w_new[k] = w_new[k] + CNT_W'(1);
    end
  end

  always_comb begin
    w_max = w_row[0];
    if (w_row[1] > w_max) w_max = w_row[1];
    if (w_row[2] > w_max) w_max = w_row[2];
    w_m = {w_row[2] == w_max, w_row[1] == w_max,
           w_row[0] == w_max};
    case (w_m)
      3'b001:  w_pred = 2'd0;
      3'b010:  w_pred = 2'd1;
      3'b100:  w_pred = 2'd2;
      3'b011:  w_pred = r_rnd[0] ? 2'd1 : 2'd0;
      3'b101:  w_pred = r_rnd[0] ? 2'd2 : 2'd0;
      3'b110:  w_pred = r_rnd[0] ? 2'd2 : 2'd1;
      default: w_pred = r_rnd;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_kill) begin
      r_state  <= S_CLEAR;
      r_crow   <= '0;
      r_ctx    <= '0;
      r_hcnt   <= '0;
      r_rnd    <= '0;
      r_mv     <= '0;
      r_choice <= '0;
      r_cv     <= 1'b0;
      r_err    <= 1'b0;
      r_cwin   <= '0;
      r_uwin   <= '0;
      r_draw   <= '0;
    end else begin
      r_state <= w_next;
      r_rnd   <= (r_rnd == 2'd2) ? 2'd0 : r_rnd + 2'd1;
      r_err   <= w_bad;
      if (r_state == S_CLEAR) r_crow <= r_crow + 1'b1;
      if (w_acc) r_mv <= move_user;
      if (r_state == S_UPDATE) begin
        if (r_choice == r_mv)
          r_draw <= r_draw + 1'b1;
        else if (f_beat(r_mv) == r_choice)
          r_cwin <= r_cwin + 1'b1;
        else
          r_uwin <= r_uwin + 1'b1;
        r_ctx <= w_ctx_n;
        if (!w_full) r_hcnt <= r_hcnt + 1'b1;
      end
      if (r_state == S_PREDICT) begin
        r_choice <= w_full ? f_beat(w_pred) : r_rnd;
        r_cv     <= w_full;
      end
    end
  end

  // Table has no reset of its own; CLEAR walks every row instead
  always_ff @(posedge clock) begin
    if (r_state == S_CLEAR) begin
      for (int k = 0; k < 3; k++) r_tab[r_crow][k] <= '0;
    end else if (!w_kill && r_state == S_UPDATE && w_full) begin
      for (int k = 0; k < 3; k++) r_tab[r_ctx][k] <= w_new[k];
    end
  end

  assign ready        = (r_state == S_IDLE);
  assign choice       = r_choice;
  assign choice_valid = r_cv;
  assign err          = r_err;
  assign comp_wins    = r_cwin;
  assign user_wins    = r_uwin;
  assign draws        = r_draw;

endmodule

// File: tb/tb_markov_predictor_n.sv
// Bench for markov_predictor_n (HIST=1, CNT_W=2) against a count-table model.
// Stimulus is random legal/illegal moves plus directed reset, clear and saturation cases.
module tb_markov_predictor_n;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_user = 2'b00;
  logic       ready;
  logic [1:0] choice;
  logic       choice_valid;
  logic       err;
  logic [7:0] comp_wins;
  logic [7:0] user_wins;
  logic [7:0] draws;

  markov_predictor_n #(.HIST(1), .CNT_W(2), .SCORE_W(8)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .move_valid(move_valid), .move_user(move_user),
    .ready(ready), .choice(choice),
    .choice_valid(choice_valid), .err(err),
    .comp_wins(comp_wins), .user_wins(user_wins),
    .draws(draws)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  int mtab [4][3];
  int mctx, mh, mcw, muw, mdr, mch, mcv;
  int m_rnd = 0;

  always @(posedge clock)
    m_rnd <= (reset || clear) ? 0 : (m_rnd + 1) % 3;

  function automatic int beat(input int m);
    return (m == 0) ? 2 : ((m == 1) ? 0 : 1);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++) mtab[r][k] = 0;
    mctx = 0; mh = 0; mcw = 0; muw = 0; mdr = 0;
    mch = 0; mcv = 0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (ready === 1'b1) return;
      @(posedge clock); #1;
    end
    n_chk++;
    $display("FAIL wait_ready: ready=%b required 1", ready);
  endtask

  task automatic do_move(input int mv);
    int rp, mx, cnt, lo, hi, p;
    move_valid = 1'b1;
    move_user  = 2'(mv);
    @(posedge clock); #1;
    move_valid = 1'b0;
    if (mch == mv) mdr++;
    else if (beat(mv) == mch) mcw++;
    else muw++;
    if (mh == 1) begin
      if (mtab[mctx][mv] == 3)
        for (int k = 0; k < 3; k++) mtab[mctx][k] /= 2;
      mtab[mctx][mv]++;
    end
    mctx = mv;
    if (mh < 1) mh++;
    @(posedge clock); #1;
    rp = m_rnd;
    @(posedge clock); #1;
    mx = 0;
    for (int k = 0; k < 3; k++)
      if (mtab[mctx][k] > mx) mx = mtab[mctx][k];
    cnt = 0; lo = -1; hi = -1;
    for (int k = 0; k < 3; k++)
      if (mtab[mctx][k] == mx) begin
        cnt++;
        if (lo < 0) lo = k;
        hi = k;
      end
    if (cnt == 1) p = lo;
    else if (cnt == 2) p = (rp % 2 == 0) ? lo : hi;
    else p = rp;
    mch = beat(p);
    mcv = 1;
    n_chk++;
    if (ready !== 1'b1 || choice_valid !== 1'(mcv)) begin
      $display("FAIL move_hs: ready=%b cv=%b required 1/%0d",
               ready, choice_valid, mcv);
    end else n_pass++;
    n_chk++;
    if (choice !== 2'(mch)) begin
      $display("FAIL move_choice: got %0d required %0d",
               choice, mch);
    end else n_pass++;
    n_chk++;
    if (comp_wins !== 8'(mcw) || user_wins !== 8'(muw)
        || draws !== 8'(mdr)) begin
      $display("FAIL move_score: got %0d/%0d/%0d required %0d/%0d/%0d",
               comp_wins, user_wins, draws, mcw, muw, mdr);
    end else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ready !== 1'b0) begin
        $display("FAIL reset_busy: cycle %0d ready=%b required 0",
                 i, ready);
      end else n_pass++;
      if (i < 3) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    n_chk++;
    if (ready !== 1'b1 || choice_valid !== 1'b0
        || choice !== 2'b00 || err !== 1'b0) begin
      $display("FAIL reset_idle: rdy=%b cv=%b ch=%0d err=%b required 1 0 0 0",
               ready, choice_valid, choice, err);
    end else n_pass++;
    n_chk++;
    if (comp_wins !== 8'd0 || user_wins !== 8'd0
        || draws !== 8'd0) begin
      $display("FAIL reset_score: got %0d/%0d/%0d required 0/0/0",
               comp_wins, user_wins, draws);
    end else n_pass++;
  endtask

  task automatic test_rock_rock();
    do_move(0);
    do_move(0);
    n_chk++;
    if (choice !== 2'b10 || choice_valid !== 1'b1) begin
      $display("FAIL rock_rock: choice=%0d cv=%b required 2 1",
               choice, choice_valid);
    end else n_pass++;
    do_move(0);
  endtask

  task automatic test_halve();
    test_reset();
    for (int i = 0; i < 5; i++) do_move(0);
    n_chk++;
    if (dut.r_tab[0][0] !== 2'd2 || dut.r_tab[0][1] !== 2'd0
        || dut.r_tab[0][2] !== 2'd0) begin
      $display("FAIL halve: row0=%0d,%0d,%0d required 2,0,0",
               dut.r_tab[0][0], dut.r_tab[0][1], dut.r_tab[0][2]);
    end else n_pass++;
    n_chk++;
    if (mtab[0][0] != 2) begin
      $display("FAIL halve_model: got %0d required 2", mtab[0][0]);
    end else n_pass++;
  endtask

  task automatic test_err();
    move_valid = 1'b1;
    move_user  = 2'b11;
    @(posedge clock); #1;
    move_valid = 1'b0;
    n_chk++;
    if (err !== 1'b1 || ready !== 1'b1) begin
      $display("FAIL err_pulse: err=%b ready=%b required 1 1",
               err, ready);
    end else n_pass++;
    @(posedge clock); #1;
    n_chk++;
    if (err !== 1'b0 || ready !== 1'b1 || comp_wins !== 8'(mcw)
        || user_wins !== 8'(muw) || draws !== 8'(mdr)) begin
      $display("FAIL err_after: err=%b rdy=%b sc=%0d/%0d/%0d required 0 1 %0d/%0d/%0d",
               err, ready, comp_wins, user_wins, draws,
               mcw, muw, mdr);
    end else n_pass++;
    do_move(1);
  endtask

  task automatic test_reset_update();
    move_valid = 1'b1;
    move_user  = 2'd1;
    @(posedge clock); #1;
    move_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    n_chk++;
    if (ready !== 1'b0 || comp_wins !== 8'd0
        || user_wins !== 8'd0 || draws !== 8'd0) begin
      $display("FAIL reset_update: rdy=%b sc=%0d/%0d/%0d required 0 0/0/0",
               ready, comp_wins, user_wins, draws);
    end else n_pass++;
    wait_ready();
    do_move(1);
    do_move(1);
  endtask

  task automatic test_clear_mid();
    test_reset();
    do_move(2);
    do_move(2);
    clear = 1'b1;
    move_valid = 1'b1;
    move_user  = 2'd0;
    @(posedge clock); #1;
    clear = 1'b0;
    move_valid = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    model_reset();
    n_chk++;
    if (ready !== 1'b0 || choice !== 2'b00
        || choice_valid !== 1'b0 || draws !== 8'd0) begin
      $display("FAIL clear_mid: rdy=%b ch=%0d cv=%b dr=%0d required 0 0 0 0",
               ready, choice, choice_valid, draws);
    end else n_pass++;
    wait_ready();
    do_move(2);
    do_move(0);
  endtask

  task automatic test_random();
    int mv;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        move_valid = 1'b1;
        move_user  = 2'b11;
        @(posedge clock); #1;
        move_valid = 1'b0;
        n_chk++;
        if (err !== 1'b1) begin
          $display("FAIL rand_err: err=%b required 1", err);
        end else n_pass++;
      end
      mv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                        : (i % 3 == 0 ? 0 : 1);
      do_move(mv);
    end
  endtask

  initial begin
    test_reset();
    test_rock_rock();
    test_halve();
    test_err();
    test_reset_update();
    test_clear_mid();
    test_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
